// File: rtl/pipeline_stall_controller_if.sv
// rtl/pipeline_stall_controller_if.sv - hazard controller bundle between pipeline registers and controller
//
// Purpose: groups the IF/ID decode inputs, EX hazard inputs and the pipeline
// enable outputs of pipeline_stall_controller into one bundle.
// Ports (signals):
//   id_inst[15:0], id_valid          instruction held in IF/ID
//   ex_rd[3:0], ex_mem_read          destination and load flag of the EX instruction
//   branch_taken                     branch in EX resolved taken
//   pc_write, if_id_write            PC / IF/ID write enables
//   if_id_flush, id_ex_bubble        IF/ID flush, ID/EX bubble insertion
//   busy, halted                     vector op in progress, controller halted
//   stall_count[15:0]                saturating stall-cycle count
// Modports: slave = controller side, master = pipeline side.

interface pipeline_stall_controller_if;
  logic [15:0] id_inst;
  logic        id_valid;
  logic [3:0]  ex_rd;
  logic        ex_mem_read;
  logic        branch_taken;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic        busy;
  logic        halted;
  logic [15:0] stall_count;

  modport slave (
    input  id_inst, id_valid, ex_rd, ex_mem_read, branch_taken,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, busy, halted, stall_count
  );

  modport master (
    output id_inst, id_valid, ex_rd, ex_mem_read, branch_taken,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, busy, halted, stall_count
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - load-use / branch / vector-op / HALT stall controller
//
// Purpose: sole source of the IF/ID and ID/EX enables for the 16-bit SIMD AES
// pipeline. Same-cycle combinational stalls, flushes and bubbles; a short
// freeze while a multi-cycle vector op occupies EX; a terminal HALT state.
// Ports:
//   clock   rising-edge clock
//   reset   asynchronous active-high reset
//   bus     pipeline_stall_controller_if.slave (decode/hazard inputs, enables out)
// Parameters: OP_VEC, OP_HALT opcodes; VEC_LATENCY total EX cycles of a vector op (1..15).
// Optional build macro: STALL_COUNTER_EN implements the saturating stall counter;
// without it stall_count is tied to zero.

module pipeline_stall_controller #(
  parameter logic [3:0]  OP_VEC      = 4'hA,
  parameter logic [3:0]  OP_HALT     = 4'hF,
  parameter int unsigned VEC_LATENCY = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  pipeline_stall_controller_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_VEC_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

  localparam logic [3:0] VEC_WAIT_CYCLES = 4'(VEC_LATENCY - 1);

  state_e     state_q, state_d;
  logic [3:0] vec_cnt_q, vec_cnt_d;

  logic       pc_write_c;
  logic       if_id_write_c;
  logic       if_id_flush_c;
  logic       id_ex_bubble_c;

  logic [3:0] opcode;
  logic [3:0] rs1;
  logic [3:0] rs2;
  logic       load_use;

  assign opcode = bus.id_inst[15:12];
  assign rs1    = bus.id_inst[7:4];
  assign rs2    = bus.id_inst[3:0];

  // r0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign load_use = bus.id_valid && bus.ex_mem_read && (bus.ex_rd != 4'h0) &&
                    ((bus.ex_rd == rs1) || (bus.ex_rd == rs2));

  always_comb begin
    state_d        = state_q;
    vec_cnt_d      = vec_cnt_q;
    pc_write_c     = 1'b1;
    if_id_write_c  = 1'b1;
    if_id_flush_c  = 1'b0;
    id_ex_bubble_c = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (bus.branch_taken) begin
          // PC still writes: it loads the branch target.
          if_id_flush_c  = 1'b1;
          id_ex_bubble_c = 1'b1;
        end else if (load_use) begin
          pc_write_c     = 1'b0;
          if_id_write_c  = 1'b0;
          id_ex_bubble_c = 1'b1;
        end else if (bus.id_valid && (opcode == OP_HALT)) begin
          pc_write_c     = 1'b0;
          if_id_write_c  = 1'b0;
          id_ex_bubble_c = 1'b1;
          state_d        = ST_HALT;
        end else if (bus.id_valid && (opcode == OP_VEC) && (VEC_LATENCY > 1)) begin
          // The vector op itself issues this cycle; the freeze starts next cycle.
          state_d   = ST_VEC_WAIT;
          vec_cnt_d = VEC_WAIT_CYCLES;
        end
      end

      ST_VEC_WAIT: begin
        pc_write_c     = 1'b0;
        if_id_write_c  = 1'b0;
        id_ex_bubble_c = 1'b1;
        vec_cnt_d      = vec_cnt_q - 4'd1;
        if (vec_cnt_q <= 4'd1) begin
          state_d = ST_RUN;
        end
      end

      ST_HALT: begin
        pc_write_c     = 1'b0;
        if_id_write_c  = 1'b0;
        id_ex_bubble_c = 1'b1;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    // While reset is held the pipeline registers are kept empty.
    if (reset) begin
      pc_write_c     = 1'b0;
      if_id_write_c  = 1'b0;
      if_id_flush_c  = 1'b1;
      id_ex_bubble_c = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RUN;
      vec_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      vec_cnt_q <= vec_cnt_d;
    end
  end

  assign bus.pc_write     = pc_write_c;
  assign bus.if_id_write  = if_id_write_c;
  assign bus.if_id_flush  = if_id_flush_c;
  assign bus.id_ex_bubble = id_ex_bubble_c;
  assign bus.busy         = (state_q == ST_VEC_WAIT);
  assign bus.halted       = (state_q == ST_HALT);

`ifdef STALL_COUNTER_EN
  logic [15:0] stall_count_q, stall_count_d;

  // The HALT issue cycle is still in RUN and counts; cycles parked in HALT do not.
  always_comb begin
    stall_count_d = stall_count_q;
    if (!pc_write_c && (state_q != ST_HALT) && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count_q <= 16'h0000;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.stall_count = stall_count_q;
`else
  assign bus.stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - self-checking bench for pipeline_stall_controller

module tb_pipeline_stall_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] id_inst;
  logic        id_valid;
  logic [3:0]  ex_rd;
  logic        ex_mem_read;
  logic        branch_taken;

  always #5 clock = ~clock;

`ifdef STALL_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  pipeline_stall_controller_if ifa ();
  pipeline_stall_controller_if ifb ();

  assign ifa.id_inst      = id_inst;
  assign ifa.id_valid     = id_valid;
  assign ifa.ex_rd        = ex_rd;
  assign ifa.ex_mem_read  = ex_mem_read;
  assign ifa.branch_taken = branch_taken;
  assign ifb.id_inst      = id_inst;
  assign ifb.id_valid     = id_valid;
  assign ifb.ex_rd        = ex_rd;
  assign ifb.ex_mem_read  = ex_mem_read;
  assign ifb.branch_taken = branch_taken;

  pipeline_stall_controller #(.VEC_LATENCY(4)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (ifa.slave)
  );

  pipeline_stall_controller #(.VEC_LATENCY(1)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (ifb.slave)
  );

  // Model: per instance, remaining frozen cycles, halted flag, stall count.
  int lat [2] = '{4, 1};
  int freeze [2];
  bit hlt [2];
  int cnt [2];

  int n_vec = 0;
  int n_err = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic bit m_load_use();
    return id_valid && ex_mem_read && (ex_rd != 4'h0) &&
           ((ex_rd == id_inst[7:4]) || (ex_rd == id_inst[3:0]));
  endfunction

  function automatic void m_ctrl(input int k, output bit pc, output bit ifw,
                                 output bit fl, output bit bub);
    if (reset)                                        {pc, ifw, fl, bub} = 4'b0011;
    else if (hlt[k] || freeze[k] > 0)                 {pc, ifw, fl, bub} = 4'b0001;
    else if (branch_taken)                            {pc, ifw, fl, bub} = 4'b1111;
    else if (m_load_use())                            {pc, ifw, fl, bub} = 4'b0001;
    else if (id_valid && id_inst[15:12] == 4'hF)      {pc, ifw, fl, bub} = 4'b0001;
    else                                              {pc, ifw, fl, bub} = 4'b1100;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        freeze[k] = 0;
        hlt[k]    = 1'b0;
        cnt[k]    = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit pc, ifw, fl, bub;
        m_ctrl(k, pc, ifw, fl, bub);
        if (!hlt[k] && !pc && cnt[k] < 65535) cnt[k]++;
        if (hlt[k]) ;
        else if (freeze[k] > 0) freeze[k]--;
        else if (branch_taken) ;
        else if (m_load_use()) ;
        else if (id_valid && id_inst[15:12] == 4'hF) hlt[k] = 1'b1;
        else if (id_valid && id_inst[15:12] == 4'hA) freeze[k] = lat[k] - 1;
      end
    end
  end

  task automatic check_dut(input int k, input logic pc, input logic ifw, input logic fl,
                           input logic bub, input logic bsy, input logic hl,
                           input logic [15:0] sc);
    bit e_pc, e_ifw, e_fl, e_bub;
    m_ctrl(k, e_pc, e_ifw, e_fl, e_bub);
    cmp($sformatf("dut%0d pc_write", k), 32'(pc), 32'(e_pc));
    cmp($sformatf("dut%0d if_id_write", k), 32'(ifw), 32'(e_ifw));
    cmp($sformatf("dut%0d if_id_flush", k), 32'(fl), 32'(e_fl));
    cmp($sformatf("dut%0d id_ex_bubble", k), 32'(bub), 32'(e_bub));
    cmp($sformatf("dut%0d busy", k), 32'(bsy), 32'(freeze[k] > 0));
    cmp($sformatf("dut%0d halted", k), 32'(hl), 32'(hlt[k]));
    cmp($sformatf("dut%0d stall_count", k), 32'(sc), CNT_EN ? 32'(cnt[k]) : 32'd0);
  endtask

  always @(negedge clock) begin
    check_dut(0, ifa.pc_write, ifa.if_id_write, ifa.if_id_flush, ifa.id_ex_bubble,
              ifa.busy, ifa.halted, ifa.stall_count);
    check_dut(1, ifb.pc_write, ifb.if_id_write, ifb.if_id_flush, ifb.id_ex_bubble,
              ifb.busy, ifb.halted, ifb.stall_count);
  end

  task automatic cyc(input logic v, input logic [15:0] inst, input logic [3:0] rd,
                     input logic mr, input logic br);
    @(posedge clock);
    #1;
    id_valid     = v;
    id_inst      = inst;
    ex_rd        = rd;
    ex_mem_read  = mr;
    branch_taken = br;
    @(negedge clock);
  endtask

  function automatic logic [31:0] ec(input int v);
    return CNT_EN ? 32'(v) : 32'd0;
  endfunction

  initial begin
    id_valid = 1'b1; id_inst = 16'h1123; ex_rd = 4'h0; ex_mem_read = 1'b0; branch_taken = 1'b0;

    // Reset then run
    @(negedge clock);
    cmp("rst flush", 32'(ifa.if_id_flush), 32'd1);
    cmp("rst bubble", 32'(ifa.id_ex_bubble), 32'd1);
    cmp("rst pc_write", 32'(ifa.pc_write), 32'd0);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    cmp("run pc_write", 32'(ifa.pc_write), 32'd1);
    cmp("run if_id_write", 32'(ifa.if_id_write), 32'd1);
    cmp("run stall_count", 32'(ifa.stall_count), 32'd0);

    // Load-use on rs1, one stall cycle
    cyc(1'b1, 16'h1532, 4'h3, 1'b1, 1'b0);
    cmp("lu pc_write", 32'(ifa.pc_write), 32'd0);
    cmp("lu bubble", 32'(ifa.id_ex_bubble), 32'd1);
    cyc(1'b1, 16'h1532, 4'h3, 1'b0, 1'b0);
    cmp("lu release pc_write", 32'(ifa.pc_write), 32'd1);
    cmp("lu stall_count", 32'(ifa.stall_count), ec(1));

    // Load to r0 never stalls
    cyc(1'b1, 16'h1502, 4'h0, 1'b1, 1'b0);
    cmp("r0 pc_write", 32'(ifa.pc_write), 32'd1);

    // Branch beats load-use
    cyc(1'b1, 16'h1532, 4'h3, 1'b1, 1'b1);
    cmp("br flush", 32'(ifa.if_id_flush), 32'd1);
    cmp("br bubble", 32'(ifa.id_ex_bubble), 32'd1);
    cmp("br pc_write", 32'(ifa.pc_write), 32'd1);
    cyc(1'b1, 16'h1123, 4'h0, 1'b0, 1'b0);
    cmp("br stall_count", 32'(ifa.stall_count), ec(1));

    // Branch beats vector issue
    cyc(1'b1, 16'hA012, 4'h0, 1'b0, 1'b1);
    cyc(1'b1, 16'h1123, 4'h0, 1'b0, 1'b0);
    cmp("br vec busy", 32'(ifa.busy), 32'd0);

    // Vector op, then back-to-back second vector op
    cyc(1'b1, 16'hA012, 4'h0, 1'b0, 1'b0);
    cmp("vec issue pc_write", 32'(ifa.pc_write), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 16'hA034, 4'h5, 1'b1, (i == 1));
      cmp("vec wait busy", 32'(ifa.busy), 32'd1);
      cmp("vec wait pc_write", 32'(ifa.pc_write), 32'd0);
    end
    cyc(1'b1, 16'hA034, 4'h0, 1'b0, 1'b0);
    cmp("vec2 issue busy", 32'(ifa.busy), 32'd0);
    cmp("vec2 issue pc_write", 32'(ifa.pc_write), 32'd1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0000, 4'h0, 1'b0, 1'b0);
    cmp("vec stall_count lat4", 32'(ifa.stall_count), ec(7));
    cmp("vec stall_count lat1", 32'(ifb.stall_count), ec(1));
    cmp("vec lat1 busy", 32'(ifb.busy), 32'd0);

    // HALT
    cyc(1'b1, 16'hF000, 4'h0, 1'b0, 1'b0);
    cmp("halt issue pc_write", 32'(ifa.pc_write), 32'd0);
    cmp("halt issue bubble", 32'(ifa.id_ex_bubble), 32'd1);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 16'h0000, 4'h3, (i == 7), (i == 5));
      cmp("halted", 32'(ifa.halted), 32'd1);
      cmp("halted pc_write", 32'(ifa.pc_write), 32'd0);
    end
    cmp("halt stall_count lat4", 32'(ifa.stall_count), ec(8));
    cmp("halt stall_count lat1", 32'(ifb.stall_count), ec(2));

    // Asynchronous reset out of HALT
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    cmp("async rst halted", 32'(ifa.halted), 32'd0);
    cmp("async rst stall_count", 32'(ifa.stall_count), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    cmp("post rst halted", 32'(ifa.halted), 32'd0);

    // Saturation under a held load-use
    for (int i = 0; i < 70000; i++) cyc(1'b1, 16'h1532, 4'h3, 1'b1, 1'b0);
    cmp("sat stall_count", 32'(ifa.stall_count), CNT_EN ? 32'h0000FFFF : 32'd0);
    cyc(1'b1, 16'h1532, 4'h3, 1'b1, 1'b0);
    cmp("sat hold stall_count", 32'(ifa.stall_count), CNT_EN ? 32'h0000FFFF : 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
